// File: rtl/mem_stage_pkg.sv
// Shared definitions for the RV32I memory stage: bus widths, CSR command bits,
// writeback select codes, the EXE->MEM bus layout and the store FSM states.
package mem_stage_pkg;

  localparam int EXE_MEM_BUS_W = 187;
  localparam int MEM_WB_BUS_W  = 70;
  localparam int MEM_ID_BUS_W  = 38;

  localparam logic [11:0] MCAUSE_ADDR_DEF = 12'h342;
  localparam logic [31:0] ECALL_CAUSE_DEF = 32'd11;

  // csr_cmd is one-hot; these are bit positions
  localparam int CSR_CMD_W     = 0;
  localparam int CSR_CMD_S     = 1;
  localparam int CSR_CMD_C     = 2;
  localparam int CSR_CMD_ECALL = 3;

  localparam logic [2:0] WB_SEL_ALU = 3'b000;
  localparam logic [2:0] WB_SEL_LD  = 3'b001;
  localparam logic [2:0] WB_SEL_PC4 = 3'b010;
  localparam logic [2:0] WB_SEL_CSR = 3'b011;

  typedef struct packed {
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        rd_wen;
    logic        mem_we;
    logic        mem_re;
    logic [2:0]  wb_sel;
    logic [31:0] pc;
    logic [31:0] wb_data;
    logic [3:0]  csr_cmd;
    logic [11:0] csr_addr;
    logic [31:0] op1;
    logic [31:0] ld_data;
  } exe_mem_bus_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } store_state_e;

endpackage

// File: rtl/mem_stage_csr_wdata_gen.sv
// Combinational CSR read-modify-write: picks the CSR write address and data
// from the one-hot command, the current CSR value and the source operand.
module mem_stage_csr_wdata_gen
  import mem_stage_pkg::*;
#(
  parameter logic [11:0] MCAUSE_ADDR = MCAUSE_ADDR_DEF,
  parameter logic [31:0] ECALL_CAUSE = ECALL_CAUSE_DEF
) (
  input  logic [3:0]  i_csr_cmd,
  input  logic [11:0] i_csr_addr,
  input  logic [31:0] i_op1,
  input  logic [31:0] i_csr_rdata,
  output logic [11:0] o_waddr,
  output logic [31:0] o_wdata
);

  always_comb begin
    o_waddr = i_csr_addr;
    o_wdata = '0;
    if (i_csr_cmd[CSR_CMD_ECALL]) begin
      o_waddr = MCAUSE_ADDR;
      o_wdata = ECALL_CAUSE;
    end else if (i_csr_cmd[CSR_CMD_C]) begin
      o_wdata = i_csr_rdata & ~i_op1;
    end else if (i_csr_cmd[CSR_CMD_S]) begin
      o_wdata = i_csr_rdata | i_op1;
    end else if (i_csr_cmd[CSR_CMD_W]) begin
      o_wdata = i_op1;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage of the RV32I pipeline: store req/ack handshake, CSR write strobe,
// writeback value selection, forwarding to ID and valid/allowin hand-off to WB.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter logic [11:0] MCAUSE_ADDR = MCAUSE_ADDR_DEF,
  parameter logic [31:0] ECALL_CAUSE = ECALL_CAUSE_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [EXE_MEM_BUS_W-1:0] exe_mem_bus_in,
  input  logic                     es_to_ms_valid,
  output logic                     ms_allowin,
  output logic                     ms_to_ws_valid,
  input  logic                     ws_allowin,
  output logic [MEM_WB_BUS_W-1:0]  mem_wb_bus_out,
  output logic [MEM_ID_BUS_W-1:0]  mem_id_data_bus,
  output logic                     dmem_wr_req,
  output logic [31:0]              dmem_wr_addr,
  output logic [31:0]              dmem_wr_data,
  input  logic                     dmem_wr_ack,
  output logic [11:0]              csr_waddr,
  output logic [31:0]              csr_wdata,
  output logic                     csr_we,
  input  logic [31:0]              csr_rdata,
  output logic [31:0]              store_stall_cnt
);

  function automatic logic [31:0] f_sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [31:0] f_wb_select(input logic [2:0]  sel,
                                              input logic [31:0] alu,
                                              input logic [31:0] ld,
                                              input logic [31:0] pc,
                                              input logic [31:0] csr);
    case (sel)
      WB_SEL_LD:  return ld;
      WB_SEL_PC4: return pc + 32'd4;
      WB_SEL_CSR: return csr;
      default:    return alu;
    endcase
  endfunction

  exe_mem_bus_t r_bus;
  logic         r_ms_valid;
  store_state_e r_state;
  store_state_e w_state_nxt;
  logic [31:0]  r_stall_cnt;

  logic         w_is_store;
  logic         w_ready_go;
  logic         w_req;
  logic         w_handoff;
  logic [31:0]  w_wb_result;
  logic         w_fwd_wen;
  logic         w_unused_mem_re;

  assign w_is_store      = r_ms_valid && r_bus.mem_we;
  assign w_unused_mem_re = r_bus.mem_re;

  // Store FSM: one ack per store; DONE remembers the consumed ack while WB stalls
  always_comb begin
    w_state_nxt = r_state;
    w_ready_go  = 1'b1;
    w_req       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_is_store) begin
          w_req      = 1'b1;
          w_ready_go = dmem_wr_ack;
          if (!dmem_wr_ack) begin
            w_state_nxt = ST_WAIT;
          end else if (!ws_allowin) begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_WAIT: begin
        w_req      = 1'b1;
        w_ready_go = dmem_wr_ack;
        if (dmem_wr_ack) begin
          w_state_nxt = ws_allowin ? ST_IDLE : ST_DONE;
        end
      end
      ST_DONE: begin
        if (ws_allowin) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign ms_allowin     = !r_ms_valid || (w_ready_go && ws_allowin);
  assign ms_to_ws_valid = r_ms_valid && w_ready_go;
  assign w_handoff      = ms_to_ws_valid && ws_allowin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ms_valid  <= 1'b0;
      r_bus       <= '0;
      r_state     <= ST_IDLE;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (ms_allowin) begin
        r_ms_valid <= es_to_ms_valid;
      end
      if (es_to_ms_valid && ms_allowin) begin
        r_bus <= exe_mem_bus_in;
      end
      if (w_req && !dmem_wr_ack) begin
        r_stall_cnt <= f_sat_inc(r_stall_cnt);
      end
    end
  end

  assign dmem_wr_req     = w_req;
  assign dmem_wr_addr    = r_bus.alu;
  assign dmem_wr_data    = r_bus.wb_data;
  assign store_stall_cnt = r_stall_cnt;

  mem_stage_csr_wdata_gen #(
    .MCAUSE_ADDR (MCAUSE_ADDR),
    .ECALL_CAUSE (ECALL_CAUSE)
  ) u_csr_wdata_gen (
    .i_csr_cmd   (r_bus.csr_cmd),
    .i_csr_addr  (r_bus.csr_addr),
    .i_op1       (r_bus.op1),
    .i_csr_rdata (csr_rdata),
    .o_waddr     (csr_waddr),
    .o_wdata     (csr_wdata)
  );

  // Strobe only on the hand-off cycle so a stalled instruction writes once
  assign csr_we = w_handoff && (r_bus.csr_cmd != 4'd0);

  assign w_wb_result = f_wb_select(r_bus.wb_sel, r_bus.alu, r_bus.ld_data,
                                   r_bus.pc, csr_rdata);
  assign w_fwd_wen   = r_ms_valid && r_bus.rd_wen && (r_bus.rd != 5'd0);

  assign mem_wb_bus_out  = {w_wb_result, r_bus.rd, r_bus.rd_wen, r_bus.pc};
  assign mem_id_data_bus = {w_wb_result, w_fwd_wen, r_bus.rd};

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against an instruction-level model.
module tb_mem_stage;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [186:0] exe_mem_bus_in;
  logic         es_to_ms_valid;
  logic         ms_allowin;
  logic         ms_to_ws_valid;
  logic         ws_allowin;
  logic [69:0]  mem_wb_bus_out;
  logic [37:0]  mem_id_data_bus;
  logic         dmem_wr_req;
  logic [31:0]  dmem_wr_addr;
  logic [31:0]  dmem_wr_data;
  logic         dmem_wr_ack;
  logic [11:0]  csr_waddr;
  logic [31:0]  csr_wdata;
  logic         csr_we;
  logic [31:0]  csr_rdata;
  logic [31:0]  store_stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .exe_mem_bus_in  (exe_mem_bus_in),
    .es_to_ms_valid  (es_to_ms_valid),
    .ms_allowin      (ms_allowin),
    .ms_to_ws_valid  (ms_to_ws_valid),
    .ws_allowin      (ws_allowin),
    .mem_wb_bus_out  (mem_wb_bus_out),
    .mem_id_data_bus (mem_id_data_bus),
    .dmem_wr_req     (dmem_wr_req),
    .dmem_wr_addr    (dmem_wr_addr),
    .dmem_wr_data    (dmem_wr_data),
    .dmem_wr_ack     (dmem_wr_ack),
    .csr_waddr       (csr_waddr),
    .csr_wdata       (csr_wdata),
    .csr_we          (csr_we),
    .csr_rdata       (csr_rdata),
    .store_stall_cnt (store_stall_cnt)
  );

  task automatic chk(input string nm, input logic [69:0] act, input logic [69:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [186:0] mk(input logic [31:0] alu, input logic [4:0] rd,
                                      input logic rd_wen, input logic mem_we,
                                      input logic mem_re, input logic [2:0] wb_sel,
                                      input logic [31:0] pc, input logic [31:0] wb_data,
                                      input logic [3:0] cmd, input logic [11:0] caddr,
                                      input logic [31:0] op1, input logic [31:0] ld);
    return {alu, rd, rd_wen, mem_we, mem_re, wb_sel, pc, wb_data, cmd, caddr, op1, ld};
  endfunction

  // Instruction-level model: which instruction sits in MEM, whether its store ack was taken
  logic         m_valid = 1'b0;
  logic         m_acked = 1'b0;
  logic [186:0] m_ins = '0;
  logic [31:0]  m_cnt = '0;

  task automatic model_step();
    logic [31:0] alu, pc, wbd, op1, ld, res, wd;
    logic [4:0]  rd;
    logic        rdw, we, store, req, ready, allow, tows, fire;
    logic [2:0]  sel;
    logic [3:0]  cmd;
    logic [11:0] ca, wa;
    if (!rst_n) begin
      m_valid = 1'b0;
      m_acked = 1'b0;
      m_ins   = '0;
      m_cnt   = '0;
      chk("rst_req",   70'(dmem_wr_req), 70'd0);
      chk("rst_tows",  70'(ms_to_ws_valid), 70'd0);
      chk("rst_csrwe", 70'(csr_we), 70'd0);
      chk("rst_cnt",   70'(store_stall_cnt), 70'd0);
      chk("rst_wbbus", mem_wb_bus_out, 70'd0);
      chk("rst_fwd",   70'(mem_id_data_bus), 70'd0);
      return;
    end
    alu = m_ins[186:155]; rd = m_ins[154:150]; rdw = m_ins[149]; we = m_ins[148];
    sel = m_ins[146:144]; pc = m_ins[143:112]; wbd = m_ins[111:80];
    cmd = m_ins[79:76]; ca = m_ins[75:64]; op1 = m_ins[63:32]; ld = m_ins[31:0];

    store = m_valid && we;
    req   = store && !m_acked;
    ready = !store || m_acked || dmem_wr_ack;
    allow = !m_valid || (ready && ws_allowin);
    tows  = m_valid && ready;
    fire  = tows && ws_allowin;

    case (sel)
      3'b001:  res = ld;
      3'b010:  res = pc + 32'd4;
      3'b011:  res = csr_rdata;
      default: res = alu;
    endcase
    wa = (cmd == 4'b1000) ? 12'h342 : ca;
    case (cmd)
      4'b0001: wd = op1;
      4'b0010: wd = csr_rdata | op1;
      4'b0100: wd = csr_rdata & ~op1;
      4'b1000: wd = 32'd11;
      default: wd = 32'd0;
    endcase

    chk("req",     70'(dmem_wr_req), 70'(req));
    chk("allowin", 70'(ms_allowin), 70'(allow));
    chk("tows",    70'(ms_to_ws_valid), 70'(tows));
    chk("csr_we",  70'(csr_we), 70'(fire && (cmd != 4'd0)));
    chk("wbbus",   mem_wb_bus_out, {res, rd, rdw, pc});
    chk("fwd",     70'(mem_id_data_bus), 70'({res, m_valid && rdw && (rd != 5'd0), rd}));
    chk("stallcnt", 70'(store_stall_cnt), 70'(m_cnt));
    if (req) begin
      chk("waddr_st", 70'(dmem_wr_addr), 70'(alu));
      chk("wdata_st", 70'(dmem_wr_data), 70'(wbd));
    end
    if (fire && (cmd != 4'd0)) begin
      chk("csr_waddr", 70'(csr_waddr), 70'(wa));
      chk("csr_wdata", 70'(csr_wdata), 70'(wd));
    end

    if (req && !dmem_wr_ack && (m_cnt != 32'hFFFF_FFFF)) m_cnt = m_cnt + 32'd1;
    if (allow) begin
      m_valid = es_to_ms_valid;
      m_acked = 1'b0;
      if (es_to_ms_valid) m_ins = exe_mem_bus_in;
    end else if (req && dmem_wr_ack) begin
      m_acked = 1'b1;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      model_step();
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          nreq, nlow, nho, nwe, kind;
    logic [31:0] cnt0;
    logic [3:0]  cmd;
    exe_mem_bus_in = '0; es_to_ms_valid = 1'b0; ws_allowin = 1'b1;
    dmem_wr_ack = 1'b0; csr_rdata = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_req",     70'(dmem_wr_req), 70'd0);
    chk("reset_tows",    70'(ms_to_ws_valid), 70'd0);
    chk("reset_allowin", 70'(ms_allowin), 70'd1);
    chk("reset_cnt",     70'(store_stall_cnt), 70'd0);
    rst_n = 1'b1;

    // ALU op handed straight through
    exe_mem_bus_in = mk(32'h10, 5'd5, 1'b1, 1'b0, 1'b0, 3'b000, 32'h1000, 32'h0,
                        4'd0, 12'h0, 32'h0, 32'h0);
    es_to_ms_valid = 1'b1;
    step();
    es_to_ms_valid = 1'b0;
    #1;
    chk("t1_wbbus",   mem_wb_bus_out, {32'h10, 5'd5, 1'b1, 32'h1000});
    chk("t1_fwdwen",  70'(mem_id_data_bus[5]), 70'd1);
    chk("t1_allowin", 70'(ms_allowin), 70'd1);
    chk("t1_tows",    70'(ms_to_ws_valid), 70'd1);

    // Store acked after three stalled cycles
    exe_mem_bus_in = mk(32'h80, 5'd0, 1'b0, 1'b1, 1'b0, 3'b000, 32'h1004, 32'hDEAD,
                        4'd0, 12'h0, 32'h0, 32'h0);
    es_to_ms_valid = 1'b1;
    cnt0 = store_stall_cnt;
    step();
    es_to_ms_valid = 1'b0;
    nreq = 0; nlow = 0; nho = 0;
    for (int k = 0; k < 6; k++) begin
      dmem_wr_ack = (k == 3);
      #1;
      if (dmem_wr_req) nreq++;
      if (!ms_allowin) nlow++;
      if (ms_to_ws_valid && ws_allowin) nho++;
      if (k == 0 || k == 2) begin
        chk("t2_addr", 70'(dmem_wr_addr), 70'h80);
        chk("t2_data", 70'(dmem_wr_data), 70'hDEAD);
      end
      step();
    end
    dmem_wr_ack = 1'b0;
    chk("t2_req_cycles", 70'(nreq), 70'd4);
    chk("t2_stall_cyc",  70'(nlow), 70'd3);
    chk("t2_handoffs",   70'(nho), 70'd1);
    chk("t2_cnt_delta",  70'(store_stall_cnt - cnt0), 70'd3);

    // Store acked in the same cycle as the request
    exe_mem_bus_in = mk(32'h84, 5'd0, 1'b0, 1'b1, 1'b0, 3'b000, 32'h1008, 32'hBEEF,
                        4'd0, 12'h0, 32'h0, 32'h0);
    es_to_ms_valid = 1'b1;
    cnt0 = store_stall_cnt;
    step();
    es_to_ms_valid = 1'b0;
    nreq = 0; nlow = 0; nho = 0;
    for (int k = 0; k < 3; k++) begin
      dmem_wr_ack = (k == 0);
      #1;
      if (dmem_wr_req) nreq++;
      if (!ms_allowin) nlow++;
      if (ms_to_ws_valid && ws_allowin) nho++;
      step();
    end
    dmem_wr_ack = 1'b0;
    chk("t3_req_cycles", 70'(nreq), 70'd1);
    chk("t3_stall_cyc",  70'(nlow), 70'd0);
    chk("t3_handoffs",   70'(nho), 70'd1);
    chk("t3_cnt_delta",  70'(store_stall_cnt - cnt0), 70'd0);

    // CSRRS
    exe_mem_bus_in = mk(32'h55, 5'd7, 1'b1, 1'b0, 1'b0, 3'b011, 32'h100C, 32'h0,
                        4'b0010, 12'h300, 32'hF0, 32'h0);
    csr_rdata = 32'h0F;
    es_to_ms_valid = 1'b1;
    step();
    es_to_ms_valid = 1'b0;
    #1;
    chk("t4_csr_we",    70'(csr_we), 70'd1);
    chk("t4_csr_wdata", 70'(csr_wdata), 70'hFF);
    chk("t4_csr_waddr", 70'(csr_waddr), 70'h300);
    chk("t4_wb_result", 70'(mem_wb_bus_out[69:38]), 70'h0F);
    step();
    chk("t4_csr_we_once", 70'(csr_we), 70'd0);

    // ECALL held by WB for two cycles
    exe_mem_bus_in = mk(32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h1010, 32'h0,
                        4'b1000, 12'h123, 32'h0, 32'h0);
    es_to_ms_valid = 1'b1;
    step();
    es_to_ms_valid = 1'b0;
    nwe = 0;
    for (int k = 0; k < 4; k++) begin
      ws_allowin = (k >= 2);
      #1;
      if (csr_we) nwe++;
      if (k == 2) begin
        chk("t5_csr_we",    70'(csr_we), 70'd1);
        chk("t5_csr_waddr", 70'(csr_waddr), 70'h342);
        chk("t5_csr_wdata", 70'(csr_wdata), 70'd11);
      end
      step();
    end
    chk("t5_we_count", 70'(nwe), 70'd1);
    ws_allowin = 1'b1;

    // Reset while a store waits for ack
    exe_mem_bus_in = mk(32'h200, 5'd0, 1'b0, 1'b1, 1'b0, 3'b000, 32'h1014, 32'hCAFE,
                        4'd0, 12'h0, 32'h0, 32'h0);
    es_to_ms_valid = 1'b1;
    dmem_wr_ack = 1'b0;
    step();
    es_to_ms_valid = 1'b0;
    step();
    step();
    #1;
    chk("t6_req_before", 70'(dmem_wr_req), 70'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_req_rst",   70'(dmem_wr_req), 70'd0);
    chk("t6_tows_rst",  70'(ms_to_ws_valid), 70'd0);
    chk("t6_csrwe_rst", 70'(csr_we), 70'd0);
    chk("t6_cnt_rst",   70'(store_stall_cnt), 70'd0);
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exe_mem_bus_in = mk(32'h300, 5'(i + 1), 1'b1, 1'b0, 1'b1, 3'b001, 32'h2000,
                          32'h0, 4'd0, 12'h0, 32'h0, 32'hA000 + 32'(i));
      es_to_ms_valid = 1'b1;
      step();
      #1;
      chk("t6_load_tows",    70'(ms_to_ws_valid), 70'd1);
      chk("t6_load_allowin", 70'(ms_allowin), 70'd1);
      chk("t6_load_result",  70'(mem_wb_bus_out[69:38]), 70'(32'hA000 + 32'(i)));
    end
    es_to_ms_valid = 1'b0;

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      es_to_ms_valid = ($urandom_range(0, 3) != 0);
      ws_allowin     = ($urandom_range(0, 3) != 0);
      dmem_wr_ack    = ($urandom_range(0, 2) == 0);
      csr_rdata      = $urandom;
      kind           = $urandom_range(0, 3);
      case ($urandom_range(0, 4))
        0:       cmd = 4'b0001;
        1:       cmd = 4'b0010;
        2:       cmd = 4'b0100;
        3:       cmd = 4'b1000;
        default: cmd = 4'b0000;
      endcase
      if (kind != 3) cmd = 4'b0000;
      exe_mem_bus_in = mk($urandom, 5'($urandom), 1'($urandom), kind == 1, kind == 2,
                          3'($urandom), $urandom, $urandom, cmd, 12'($urandom),
                          ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom, $urandom);
      step();
    end
    es_to_ms_valid = 1'b0;
    ws_allowin = 1'b1;
    dmem_wr_ack = 1'b1;
    step();
    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
